// File: rtl/stim_pkg.sv
// Shared types and LFSR helpers for the stimulus generator.
package stim_pkg;

   typedef enum logic [1:0] {
      M_RANDOM = 2'd0,
      M_WALK   = 2'd1,
      M_COUNT  = 2'd2,
      M_HOLD   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
   endfunction

   // A zero seed would lock the LFSR up, so it falls back to the default.
   function automatic logic [31:0] seed_fix(input logic [31:0] v, input logic [31:0] fallback);
      return (v == '0) ? fallback : v;
   endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 32-bit Galois LFSR with seed load; load and en together step from the new seed.
module stim_lfsr
   import stim_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_2468
) (
   input  logic        clock,
   input  logic        DEFAULT_RESET,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic [31:0] value
);

   logic [31:0] base;

   always_comb base = load ? seed_fix(load_val, SEED) : value;

   always_ff @(posedge clock or negedge DEFAULT_RESET) begin
      if (!DEFAULT_RESET) begin
         value <= SEED;
      end else if (en) begin
         value <= lfsr_step(base);
      end else if (load) begin
         value <= base;
      end
   end

endmodule

// File: rtl/stim_gen.sv
// Stimulus generator: IDLE/RUN/DONE sequencer emitting TRACE_LEN words in one of
// four modes (random, walking one, count, hold).
module stim_gen
   import stim_pkg::*;
#(
   parameter int unsigned N_CH      = 10,
   parameter int unsigned CH_W      = 2,
   parameter int unsigned TRACE_LEN = 10,
   parameter logic [31:0] SEED      = 32'hACE1_2468
) (
   input  logic                   clock,
   input  logic                   DEFAULT_RESET,
   input  logic                   start,
   input  logic                   abort,
   input  logic [1:0]             mode,
   input  logic                   seed_load,
   input  logic [31:0]            seed_val,
   output logic [N_CH*CH_W-1:0]   stim,
   output logic                   stim_valid,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            cyc_cnt
);

   localparam int unsigned W = N_CH * CH_W;

   if (W < 1 || W > 32) begin : g_bad_width
      $error("stim_gen: N_CH*CH_W must be 1..32");
   end
   if (TRACE_LEN < 1 || TRACE_LEN > 65535) begin : g_bad_len
      $error("stim_gen: TRACE_LEN must be 1..65535");
   end
   if (SEED == 32'h0) begin : g_bad_seed
      $error("stim_gen: SEED must be non-zero");
   end

   state_t        state, state_nxt;
   mode_t         mode_q, mode_nxt;
   logic [W-1:0]  stim_nxt;
   logic [15:0]   cnt_nxt;
   logic          lfsr_en, lfsr_load;
   logic [31:0]   lfsr_val, seed_eff, lfsr_adv, unused_adv;

   function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
      return (x << 1) | (x >> (W - 1));
   endfunction

   // A seed loaded in the start cycle must already be visible to the first word.
   assign lfsr_load  = seed_load && (state == S_IDLE);
   assign seed_eff   = lfsr_load ? seed_fix(seed_val, SEED) : lfsr_val;
   assign lfsr_adv   = lfsr_step(seed_eff);
   assign unused_adv = lfsr_adv;

   stim_lfsr #(
      .SEED(SEED)
   ) u_lfsr (
      .clock         (clock),
      .DEFAULT_RESET (DEFAULT_RESET),
      .en            (lfsr_en),
      .load          (lfsr_load),
      .load_val      (seed_val),
      .value         (lfsr_val)
   );

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      stim_nxt  = '0;
      cnt_nxt   = cyc_cnt;
      lfsr_en   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               mode_nxt  = mode_t'(mode);
               cnt_nxt   = 16'd1;
               lfsr_en   = (mode_t'(mode) != M_HOLD);
               case (mode_t'(mode))
                  M_RANDOM: stim_nxt = lfsr_adv[W-1:0];
                  M_WALK:   stim_nxt = W'(1);
                  M_COUNT:  stim_nxt = '0;
                  M_HOLD:   stim_nxt = seed_eff[W-1:0];
                  default:  stim_nxt = '0;
               endcase
            end
         end
         S_RUN: begin
            // abort wins over completion of the final word
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (cyc_cnt == 16'(TRACE_LEN)) begin
               state_nxt = S_DONE;
            end else begin
               cnt_nxt = cyc_cnt + 16'd1;
               lfsr_en = (mode_q != M_HOLD);
               case (mode_q)
                  M_RANDOM: stim_nxt = lfsr_adv[W-1:0];
                  M_WALK:   stim_nxt = rotl1(stim);
                  M_COUNT:  stim_nxt = stim + W'(1);
                  M_HOLD:   stim_nxt = stim;
                  default:  stim_nxt = '0;
               endcase
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge DEFAULT_RESET) begin
      if (!DEFAULT_RESET) begin
         state   <= S_IDLE;
         mode_q  <= M_RANDOM;
         stim    <= '0;
         cyc_cnt <= '0;
      end else begin
         state   <= state_nxt;
         mode_q  <= mode_nxt;
         stim    <= stim_nxt;
         cyc_cnt <= cnt_nxt;
      end
   end

   assign busy       = (state == S_RUN);
   assign stim_valid = busy;
   assign done       = (state == S_DONE);

endmodule

// File: tb/tb_stim_gen.sv
// Scoreboard bench for stim_gen: default instance plus a TRACE_LEN=22 instance.
module tb_stim_gen;

   localparam int unsigned W    = 20;
   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [31:0] MASK = 32'h8020_0003;

   typedef struct {
      bit           is_done;
      logic [W-1:0] data;
      int unsigned  cnt;
   } ev_t;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        start_i [2];
   logic        abort_i [2];
   logic        seed_load_i [2];
   logic [1:0]  mode_i [2];
   logic [31:0] seed_val_i [2];
   logic [W-1:0] stim_o [2];
   logic        valid_o [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic [15:0] cnt_o [2];

   ev_t         sb0[$];
   ev_t         sb1[$];
   logic [31:0] m_lfsr [2];
   bit          prev_valid [2];
   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clock = ~clock;

   stim_gen dut (
      .clock         (clock),
      .DEFAULT_RESET (rst_n),
      .start         (start_i[0]),
      .abort         (abort_i[0]),
      .mode          (mode_i[0]),
      .seed_load     (seed_load_i[0]),
      .seed_val      (seed_val_i[0]),
      .stim          (stim_o[0]),
      .stim_valid    (valid_o[0]),
      .busy          (busy_o[0]),
      .done          (done_o[0]),
      .cyc_cnt       (cnt_o[0])
   );

   stim_gen #(
      .TRACE_LEN(22)
   ) dut_w (
      .clock         (clock),
      .DEFAULT_RESET (rst_n),
      .start         (start_i[1]),
      .abort         (abort_i[1]),
      .mode          (mode_i[1]),
      .seed_load     (seed_load_i[1]),
      .seed_val      (seed_val_i[1]),
      .stim          (stim_o[1]),
      .stim_valid    (valid_o[1]),
      .busy          (busy_o[1]),
      .done          (done_o[1]),
      .cyc_cnt       (cnt_o[1])
   );

   function automatic int unsigned tl(input int d);
      return (d == 0) ? 10 : 22;
   endfunction

   // Reference LFSR: shift right, fold the mask back in when a one falls out.
   function automatic logic [31:0] model_step(input logic [31:0] v);
      logic [31:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ MASK;
      return r;
   endfunction

   function automatic void sb_push(input int d, input ev_t e);
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
   endfunction

   function automatic int sb_size(input int d);
      return (d == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic ev_t sb_pop(input int d);
      if (d == 0) return sb0.pop_front();
      return sb1.pop_front();
   endfunction

   function automatic void sb_clear(input int d);
      if (d == 0) sb0.delete(); else sb1.delete();
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic bump_fail(input string nm, input string detail);
      total++;
      bad++;
      $display("FAIL %s: %s", nm, detail);
   endtask

   always @(negedge clock) begin : monitor
      ev_t e;
      for (int d = 0; d < 2; d++) begin
         if (valid_o[d]) begin
            if (sb_size(d) == 0) begin
               bump_fail($sformatf("dut%0d_extra_word", d),
                         $sformatf("got stim %0h, want no word", stim_o[d]));
            end else begin
               e = sb_pop(d);
               if (e.is_done)
                  bump_fail($sformatf("dut%0d_word_count", d),
                            $sformatf("got extra word %0h, want done", stim_o[d]));
               else
                  chk($sformatf("dut%0d_word", d), 32'(stim_o[d]), 32'(e.data));
            end
         end else begin
            chk($sformatf("dut%0d_idle_stim_zero", d), 32'(stim_o[d]), 32'h0);
         end
         chk($sformatf("dut%0d_busy", d), 32'(busy_o[d]), 32'(valid_o[d]));
         if (done_o[d]) begin
            if (sb_size(d) == 0) begin
               bump_fail($sformatf("dut%0d_extra_done", d), "got done, want none");
            end else begin
               e = sb_pop(d);
               if (!e.is_done) begin
                  bump_fail($sformatf("dut%0d_early_done", d),
                            $sformatf("got done, want word %0h", e.data));
               end else begin
                  chk($sformatf("dut%0d_done_cyc_cnt", d), 32'(cnt_o[d]), e.cnt);
                  chk($sformatf("dut%0d_done_follows_word", d), 32'(prev_valid[d]), 32'h1);
               end
            end
         end
         prev_valid[d] = valid_o[d];
      end
   end

   task automatic check_zero(input int d, input string tag);
      chk($sformatf("%s%0d_stim", tag, d),    32'(stim_o[d]),  32'h0);
      chk($sformatf("%s%0d_valid", tag, d),   32'(valid_o[d]), 32'h0);
      chk($sformatf("%s%0d_busy", tag, d),    32'(busy_o[d]),  32'h0);
      chk($sformatf("%s%0d_done", tag, d),    32'(done_o[d]),  32'h0);
      chk($sformatf("%s%0d_cyc_cnt", tag, d), 32'(cnt_o[d]),   32'h0);
   endtask

   task automatic wait_drain(input int d);
      int unsigned n = 0;
      while (sb_size(d) != 0 && n < 64) begin
         @(negedge clock);
         n++;
      end
      chk($sformatf("dut%0d_drain_left", d), sb_size(d), 32'h0);
      sb_clear(d);
      repeat (2) @(negedge clock);
   endtask

   task automatic load_seed(input int d, input logic [31:0] v);
      @(negedge clock);
      seed_load_i[d] = 1'b1;
      seed_val_i[d]  = v;
      m_lfsr[d]      = (v == 0) ? SEED : v;
      @(negedge clock);
      seed_load_i[d] = 1'b0;
   endtask

   // ab: abort during word ab (0 = none); poke: raise start+seed_load during word poke.
   task automatic do_run(input int d, input int md, input bit ld, input logic [31:0] sv,
                         input int unsigned ab, input int unsigned poke);
      int unsigned n;
      logic [31:0] hold;
      ev_t e;
      @(negedge clock);
      if (ld) m_lfsr[d] = (sv == 0) ? SEED : sv;
      start_i[d]     = 1'b1;
      mode_i[d]      = 2'(md);
      seed_load_i[d] = ld;
      seed_val_i[d]  = sv;
      n    = (ab != 0) ? ab : tl(d);
      hold = m_lfsr[d];
      for (int unsigned j = 0; j < n; j++) begin
         e.is_done = 1'b0;
         e.cnt     = 0;
         case (md)
            0: begin m_lfsr[d] = model_step(m_lfsr[d]); e.data = m_lfsr[d][W-1:0]; end
            1: begin m_lfsr[d] = model_step(m_lfsr[d]); e.data = W'(1) << (j % W); end
            2: begin m_lfsr[d] = model_step(m_lfsr[d]); e.data = W'(j); end
            default: e.data = hold[W-1:0];
         endcase
         sb_push(d, e);
      end
      if (ab == 0) begin
         e.is_done = 1'b1;
         e.data    = '0;
         e.cnt     = tl(d);
         sb_push(d, e);
      end
      for (int unsigned c = 1; c <= n; c++) begin
         @(negedge clock);
         start_i[d]     = 1'b0;
         seed_load_i[d] = 1'b0;
         if (c == poke) begin
            start_i[d]     = 1'b1;
            seed_load_i[d] = 1'b1;
            seed_val_i[d]  = $urandom;
         end
         if (c == ab) abort_i[d] = 1'b1;
      end
      @(negedge clock);
      start_i[d]     = 1'b0;
      seed_load_i[d] = 1'b0;
      abort_i[d]     = 1'b0;
      if (ab != 0) begin
         chk($sformatf("dut%0d_abort_cyc_cnt", d), 32'(cnt_o[d]), ab);
         chk($sformatf("dut%0d_abort_valid", d),   32'(valid_o[d]), 32'h0);
         chk($sformatf("dut%0d_abort_stim", d),    32'(stim_o[d]), 32'h0);
      end
      wait_drain(d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      ev_t e;
      for (int d = 0; d < 2; d++) begin
         start_i[d] = 1'b0; abort_i[d] = 1'b0; seed_load_i[d] = 1'b0;
         mode_i[d] = 2'd0; seed_val_i[d] = 32'h0; m_lfsr[d] = SEED;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_zero(0, "rst");
      check_zero(1, "rst");
      repeat (2) @(negedge clock);
      rst_n = 1'b1;

      do_run(0, 0, 1'b0, 32'h0, 0, 0);            // RANDOM from reset seed
      do_run(0, 2, 1'b0, 32'h0, 0, 0);            // COUNT 0..9
      do_run(1, 1, 1'b0, 32'h0, 0, 0);            // WALK over 22 words, wraps
      do_run(0, 0, 1'b1, 32'h0, 0, 0);            // seed 0 -> SEED, same as reset run
      do_run(0, 2, 1'b0, 32'h0, 4, 2);            // abort in word 4, start ignored
      load_seed(0, 32'h0001_2345);
      do_run(0, 3, 1'b0, 32'h0, 0, 0);            // HOLD 0x12345
      do_run(0, 0, 1'b0, 32'h0, 0, 0);            // LFSR resumes from 0x12345
      do_run(0, 1, 1'b0, 32'h0, 10, 0);           // abort on the final word
      do_run(0, 0, 1'b1, 32'hDEAD_BEEF, 0, 0);    // load and start together

      for (int i = 0; i < 40; i++) begin
         int d;
         int unsigned ab, lim, poke;
         d    = $urandom_range(0, 1);
         ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, tl(d)) : 0;
         lim  = (ab != 0) ? ab - 1 : tl(d);
         poke = ($urandom_range(0, 1) == 0) ? $urandom_range(0, lim) : 0;
         do_run(d, $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, ab, poke);
      end

      // Asynchronous reset in the middle of a COUNT run.
      @(negedge clock);
      start_i[0] = 1'b1;
      mode_i[0]  = 2'd2;
      for (int unsigned j = 0; j < 3; j++) begin
         e.is_done = 1'b0; e.cnt = 0; e.data = W'(j);
         sb_push(0, e);
      end
      @(negedge clock);
      start_i[0] = 1'b0;
      repeat (2) @(negedge clock);
      @(posedge clock);
      #3;
      rst_n = 1'b0;
      chk("midrst_words_seen", sb_size(0), 32'h0);
      sb_clear(0);
      m_lfsr[0] = SEED;
      m_lfsr[1] = SEED;
      #1;
      check_zero(0, "midrst");
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      do_run(0, 2, 1'b0, 32'h0, 0, 0);            // COUNT again from 0
      do_run(0, 0, 1'b0, 32'h0, 0, 0);            // RANDOM again from SEED

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stim_gen.md
STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 Parameter N_CH, default 10, number of stimulus channels.
REQ-002 Parameter CH_W, default 2, bits per channel; N_CH*CH_W SHALL be 1..32, and any other value SHALL be an elaboration error.
REQ-003 Parameter TRACE_LEN, default 10, words per run; it SHALL be 1..65535.
REQ-004 Parameter SEED, default 32'hACE1_2468, LFSR reset and fallback seed; 0 SHALL be an elaboration error.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 DEFAULT_RESET  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin a run; honoured in IDLE only.
REQ-008 abort  in  1  terminate a run immediately.
REQ-009 mode  in  2  0 RANDOM, 1 WALK, 2 COUNT, 3 HOLD; latched on the accepted start.
REQ-010 seed_load  in  1  load seed_val into the LFSR; honoured in IDLE only.
REQ-011 seed_val  in  32  user seed.
REQ-012 stim  out  N_CH*CH_W  stimulus word; channel i occupies bits [i*CH_W +: CH_W].
REQ-013 stim_valid  out  1  stim carries a trace word.
REQ-014 busy  out  1  state is RUN.
REQ-015 done  out  1  one-cycle pulse after a completed run.
REQ-016 cyc_cnt  out  16  number of words emitted in the current or last run.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after TRACE_LEN words.
- DONE->IDLE unconditionally on the next cycle.
REQ-018 A start accepted at edge k SHALL present the first word, with stim_valid=1, from edge k; stim_valid SHALL be 1 for exactly TRACE_LEN consecutive cycles.
REQ-019 The LFSR SHALL be a 32-bit Galois LFSR with feedback mask 32'h8020_0003, shifted right, advancing once per cycle in RUN and only in RUN.
REQ-020 stim SHALL be generated per latched mode:
- RANDOM: each word is the low N_CH*CH_W bits of the LFSR's next value.
- WALK: first word has bit 0 set; each later word rotates left by 1, wrapping from the MSB to bit 0.
- COUNT: first word is 0; each later word is +1, modulo 2^(N_CH*CH_W).
- HOLD: every word equals the low N_CH*CH_W bits of the LFSR at start; the LFSR does not advance.
REQ-021 cyc_cnt SHALL reset to 0 on start, increment per emitted word and hold its value through DONE and IDLE.
REQ-022 done SHALL pulse in DONE only, i.e. the cycle after the last valid word.
REQ-023 When abort is high in RUN, the next edge SHALL go to IDLE with stim_valid=0, stim=0, no done pulse and cyc_cnt holding its value.
REQ-024 abort SHALL take priority over run completion in the same cycle.
REQ-025 start or seed_load while in RUN or DONE SHALL be ignored.
REQ-026 If seed_load and start are both high in IDLE, the seed SHALL load first and the run SHALL use the new seed.
REQ-027 seed_val=0 SHALL load SEED instead, so the LFSR never locks up.
REQ-028 When stim_valid=0, stim SHALL be 0.

Reset
REQ-029 While DEFAULT_RESET is low, the block SHALL hold the following regardless of clock:
- state=IDLE, stim=0, stim_valid=0, busy=0, done=0, cyc_cnt=0;
- LFSR=SEED, latched mode=RANDOM.
REQ-030 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-031 The first start after reset release SHALL behave as from cold.

Structure
REQ-032 A shared package stim_pkg SHALL hold the mode enum, the FSM state enum and the LFSR_MASK constant.
REQ-033 The LFSR SHALL be one sub-module, stim_lfsr, with ports clock, DEFAULT_RESET, en, load, load_val and value.
REQ-034 The FSM, the mode generators and the counter SHALL reside in stim_gen.

Verification
REQ-035 All scenarios SHALL use defaults (stim width 20 bits) unless stated:
- COUNT run: start with mode=2 -> stim 0x00000..0x00009 on 10 consecutive valid cycles; done pulses once the next cycle; cyc_cnt=10.
- WALK with TRACE_LEN=22 -> stim 0x00001, 0x00002, ..., 0x80000, then 0x00001, 0x00002; bit 19 wraps to bit 0.
- RANDOM after seed_load with seed_val=0 -> word sequence identical to a run from reset (seed SEED), checked against a Galois mask 32'h8020_0003 software model.
- Abort: abort during the 4th valid cycle -> next edge stim_valid=0, stim=0, no done pulse, cyc_cnt=4; start ignored mid-run.
- HOLD: seed_load 32'h0001_2345 then start mode=3 -> stim=0x12345 for all 10 words; the LFSR does not advance.
- Reset: DEFAULT_RESET low mid-run, asynchronously between clock edges -> outputs go to 0 immediately; after release, a COUNT run again starts at 0.
